// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine: shift-add multiply and restoring
// divide, one bit per clock, with a registered result and done pulse.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              done_q, done_d;

  logic              is_div, a_sgn, b_sgn;
  logic              neg_a, neg_b, div0, ovf;
  logic [XLEN-1:0]   mag_a, mag_b, spec_res;
  logic              carry;
  logic [XLEN-1:0]   sum, addend, diff;
  logic [XLEN:0]     hi;
  logic              ge;
  logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
  logic [XLEN-1:0]   quot, rem, q_fix, r_fix, fix_res;

  assign is_div = funct3[2];
  assign a_sgn  = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign b_sgn  = is_div ? ~funct3[0] : ~funct3[1];
  assign neg_a  = a_sgn & op_a[XLEN-1];
  assign neg_b  = b_sgn & op_b[XLEN-1];
  assign mag_a  = neg_a ? -op_a : op_a;
  assign mag_b  = neg_b ? -op_b : op_b;
  assign div0   = is_div & (op_b == '0);
  assign ovf    = is_div & ~funct3[0]
                & (op_a == {1'b1, {(XLEN-1){1'b0}}})
                & (&op_b);

  // Divide-by-zero and signed overflow resolve without iterating.
  always_comb begin
    spec_res = '0;
    if (div0)
      spec_res = funct3[1] ? op_a : '1;
    else if (ovf)
      spec_res = funct3[1] ? '0 : op_a;
  end

  assign addend         = acc_q[0] ? dvs_q : '0;
  assign {carry, sum}   = {1'b0, acc_q[2*XLEN-1:XLEN]}
                        + {1'b0, addend};
  assign mul_next       = {carry, sum, acc_q[XLEN-1:1]};

  assign hi       = acc_q[2*XLEN-1:XLEN-1];
  assign ge       = hi >= {1'b0, dvs_q};
  assign diff     = hi[XLEN-1:0] - dvs_q;
  assign div_next = ge ? {diff, acc_q[XLEN-2:0], 1'b1}
                       : {acc_q[2*XLEN-2:0], 1'b0};

  assign prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign quot     = acc_q[XLEN-1:0];
  assign rem      = acc_q[2*XLEN-1:XLEN];
  assign q_fix    = (sa_q ^ sb_q) ? -quot : quot;
  assign r_fix    = sa_q ? -rem : rem;

  always_comb begin
    case (op_q)
      3'b000:  fix_res = prod_fix[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011:  fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100,
      3'b101:  fix_res = q_fix;
      default: fix_res = r_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        op_d  = funct3;
        sa_d  = neg_a;
        sb_d  = neg_b;
        cnt_d = '0;
        if (div0 | ovf) begin
          res_d   = spec_res;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          acc_d   = {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
          dvs_d   = is_div ? mag_b : mag_a;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN-1))
          state_d = FIX;
      end
      FIX: begin
        res_d   = fix_res;
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      acc_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign stall  = ((state_q == IDLE) & start)
                | (state_q == CALC)
                | (state_q == FIX);
  assign done   = done_q;
  assign result = res_q;

endmodule
